fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset, sampled only on the rising edge of clk.
REQ-003 The block SHALL have port stall, input, 1 bit: hold request from the hazard unit.
REQ-004 The block SHALL have ports is_branch, is_jal and is_jr, each input, 1 bit: decode-stage control flags for the instruction currently in D.
REQ-005 The block SHALL have port d_instr, input, 32 bits: the instruction in D; the block uses imm16 = [15:0] and imm26 = [25:0].
REQ-006 The block SHALL have port d_pc, input, 32 bits: the PC of the instruction in D.
REQ-007 The block SHALL have ports rs_data and rt_data, each input, 32 bits: forwarded register values for the D instruction.
REQ-008 The block SHALL have port imem_addr, output, 32 bits: the instruction-memory address, equal to f_pc.
REQ-009 The block SHALL have port imem_rdata, input, 32 bits: the combinational instruction-memory read data.
REQ-010 The block SHALL have port f_pc, output, 32 bits: the current fetch PC.
REQ-011 The block SHALL have ports fd_instr, fd_pc and fd_valid, outputs of 32, 32 and 1 bits: the F/D pipeline register.

Function
REQ-012 Each cycle, the block SHALL present imem_addr = f_pc, and imem_rdata SHALL be the instruction fetched in F.
REQ-013 The redirect target SHALL be selected with priority jr > jal > branch, since decode never asserts more than one flag.
- jr: target = rs_data.
- jal: target = {pc4[31:28], imm26, 2'b00}, where pc4 = d_pc+4.
- branch: target = pc4 + (sign-extended imm16 << 2).
REQ-014 A branch SHALL be taken only when rs_data == rt_data (beq); a not-taken branch SHALL behave as no redirect.
REQ-015 The redirect condition SHALL be redir = is_jr | is_jal | (is_branch & rs_data == rt_data).
REQ-016 With stall=0, on the rising edge the block SHALL update f_pc to the redirect target if redir, else to f_pc+4.
- On that edge, F/D SHALL load {imem_rdata, f_pc, 1}, except as modified by REQ-025.
REQ-017 With stall=1, f_pc, fd_instr, fd_pc and fd_valid SHALL all hold, and redir SHALL be ignored.
- The held D instruction re-presents its redirect on the first unstalled cycle.
REQ-018 Stall and redir asserted together SHALL resolve to the stall behaviour only.
REQ-019 PC arithmetic SHALL be 32-bit modulo 2^32; f_pc+4 wraps from 0xFFFF_FFFC to 0x0000_0000 without error.
REQ-020 The redirect target SHALL be used unmodified, with no alignment check; a misaligned jr target is fetched as given.
REQ-021 fd_instr SHALL be 32'h0000_0000 (nop) whenever fd_valid=0.

Reset
REQ-022 When reset_n=0 on a rising edge, the block SHALL set f_pc=32'h0000_3000, fd_instr=0, fd_pc=0 and fd_valid=0, regardless of stall or redir.
REQ-023 Reset asserted mid-stall or mid-redirect SHALL discard the pending action, and fetch SHALL restart at 0x0000_3000 on the first edge with reset_n=1.

Configuration
REQ-024 Macro FETCH_DELAY_SLOT_EN SHALL select the delay-slot behaviour.
REQ-025 When FETCH_DELAY_SLOT_EN is defined, the instruction fetched alongside an unstalled redirect (the delay slot) SHALL load into F/D normally, with fd_valid=1.
REQ-026 When FETCH_DELAY_SLOT_EN is undefined, an unstalled redirect SHALL load F/D with fd_instr=0, fd_pc=0 and fd_valid=0, squashing the slot.

Structure
REQ-027 The shared package SHALL hold the following, used by fetch_unit and the decode controller:
- constant RESET_PC = 32'h0000_3000;
- constant NOP_INSTR = 32'h0;
- the npc-select enum {SEQ, BRANCH, JAL, JR}.
REQ-028 Target computation SHALL live in one combinational sub-module, npc, whose inputs are d_pc, d_instr, rs_data, rt_data and the is_* flags, and whose outputs are redir and target.
- Registers SHALL remain in fetch_unit.

Verification
REQ-029 Reset then 3 free cycles -> f_pc SHALL go 0x3000, 0x3004, 0x3008, 0x300C; fd_pc SHALL lag f_pc by one cycle; fd_valid SHALL be 1 from the second edge.
REQ-030 d_pc=0x3010, is_branch=1, imm16=0xFFFC, rs_data=rt_data=5 -> next f_pc SHALL be 0x3004.
- Not-taken variant (rt_data=6) -> next f_pc SHALL be f_pc+4.
REQ-031 is_jal=1, d_pc=0x3020, imm26=0x0000C40 -> next f_pc SHALL be 0x0000_3100.
- With FETCH_DELAY_SLOT_EN undefined, fd_valid SHALL be 0 and fd_instr SHALL be 0 for that cycle.
- With it defined, fd_valid SHALL be 1 and fd_pc SHALL equal the slot PC.
REQ-032 stall=1 for 2 cycles while is_jr=1 and rs_data=0x0000_4000 -> f_pc and F/D SHALL hold both cycles; on the first unstalled edge f_pc SHALL become 0x4000.
REQ-033 Force f_pc to 0xFFFF_FFFC via jr -> the next sequential f_pc SHALL be 0x0000_0000.
REQ-034 reset_n=0 during stall=1 with is_branch taken -> f_pc SHALL be 0x3000 and fd_valid SHALL be 0 after the edge.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: reset vector, nop encoding and next-PC select.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEQ    = 2'd0,
    BRANCH = 2'd1,
    JAL    = 2'd2,
    JR     = 2'd3
  } npc_sel_t;

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_npc.sv
// npc: combinational redirect decision and target for the instruction in D.
module npc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] d_pc,
  input  logic [31:0] d_instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jr,
  output logic        redir,
  output logic [31:0] target
);

  logic [31:0] pc4;
  logic [31:0] branch_off;
  logic [31:0] branch_target;
  logic [31:0] jal_target;
  logic        beq_taken;
  npc_sel_t    sel;

  assign pc4 = pc_plus4(d_pc);

  // Word offset: imm16 shifted left by two and sign-extended from bit 15.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_off
      if (gi < 2) begin : g_zero
        assign branch_off[gi] = 1'b0;
      end else if (gi < 18) begin : g_imm
        assign branch_off[gi] = d_instr[gi-2];
      end else begin : g_sign
        assign branch_off[gi] = d_instr[15];
      end
    end
  endgenerate

  assign branch_target = pc4 + branch_off;
  assign jal_target    = {pc4[31:28], d_instr[25:0], 2'b00};
  assign beq_taken     = is_branch && (rs_data == rt_data);

  always_comb begin
    sel = SEQ;
    if (is_jr)          sel = JR;
    else if (is_jal)    sel = JAL;
    else if (beq_taken) sel = BRANCH;
  end

  always_comb begin
    redir  = 1'b1;
    target = pc4;
    unique case (sel)
      JR:      target = rs_data;
      JAL:     target = jal_target;
      BRANCH:  target = branch_target;
      default: redir  = 1'b0;
    endcase
  end

  logic unused_instr_bits;
  assign unused_instr_bits = &{1'b0, d_instr[31:26]};

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, F/D pipeline register and stall/redirect sequencing.
// Define FETCH_DELAY_SLOT_EN to keep the delay-slot instruction instead of squashing it.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jr,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] f_pc,
  output logic [31:0] fd_instr,
  output logic [31:0] fd_pc,
  output logic        fd_valid
);

  logic [31:0] f_pc_reg,     f_pc_next;
  logic [31:0] fd_instr_reg, fd_instr_next;
  logic [31:0] fd_pc_reg,    fd_pc_next;
  logic        fd_valid_reg, fd_valid_next;

  logic        redir;
  logic [31:0] target;

  npc u_npc (
    .d_pc      (d_pc),
    .d_instr   (d_instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .is_branch (is_branch),
    .is_jal    (is_jal),
    .is_jr     (is_jr),
    .redir     (redir),
    .target    (target)
  );

  // Stall wins over redirect: the held D instruction re-presents it later.
  always_comb begin
    f_pc_next     = f_pc_reg;
    fd_instr_next = fd_instr_reg;
    fd_pc_next    = fd_pc_reg;
    fd_valid_next = fd_valid_reg;
    if (!stall) begin
      f_pc_next     = redir ? target : pc_plus4(f_pc_reg);
      fd_instr_next = imem_rdata;
      fd_pc_next    = f_pc_reg;
      fd_valid_next = 1'b1;
`ifdef FETCH_DELAY_SLOT_EN
`else
      if (redir) begin
        fd_instr_next = NOP_INSTR;
        fd_pc_next    = 32'h0;
        fd_valid_next = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      f_pc_reg     <= RESET_PC;
      fd_instr_reg <= NOP_INSTR;
      fd_pc_reg    <= 32'h0;
      fd_valid_reg <= 1'b0;
    end else begin
      f_pc_reg     <= f_pc_next;
      fd_instr_reg <= fd_instr_next;
      fd_pc_reg    <= fd_pc_next;
      fd_valid_reg <= fd_valid_next;
    end
  end

  assign f_pc      = f_pc_reg;
  assign imem_addr = f_pc_reg;
  assign fd_instr  = fd_instr_reg;
  assign fd_pc     = fd_pc_reg;
  assign fd_valid  = fd_valid_reg;

endmodule
